// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: walk-left, walk-right, bounce and binary count,
// advanced by edges of an asynchronous slow tick and gated by ENABLE.
module led_pattern_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             TICK_IN,
  input  logic             ENABLE,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] LED,
  output logic             STEP_PULSE
);

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] LED_BIT0 = WIDTH'(1);
  localparam logic [WIDTH-1:0] LED_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  logic  s1, s2, s3;
  logic  tick;
  mode_e mode_q;
  dir_e  dir_q;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] x);
    return {x[0], x[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] start_value(input mode_e m);
    case (m)
      MODE_LEFT:   return LED_BIT0;
      MODE_RIGHT:  return LED_MSB;
      MODE_BOUNCE: return LED_BIT0;
      default:     return '0;
    endcase
  endfunction

  // Synchronizer flops reset high so a level already high at release is not an edge.
  assign tick = s2 & ~s3;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      s3         <= 1'b1;
      LED        <= LED_BIT0;
      STEP_PULSE <= 1'b0;
      mode_q     <= MODE_LEFT;
      dir_q      <= DIR_UP;
    end else begin
      s1 <= TICK_IN;
      s2 <= s1;
      s3 <= s2;
      STEP_PULSE <= 1'b0;
      if (tick && ENABLE) begin
        STEP_PULSE <= 1'b1;
        if (mode_e'(MODE) != mode_q) begin
          // A mode change consumes the step to load the new start value.
          mode_q <= mode_e'(MODE);
          LED    <= start_value(mode_e'(MODE));
          dir_q  <= DIR_UP;
        end else begin
          case (mode_q)
            MODE_LEFT:  LED <= rot_left(LED);
            MODE_RIGHT: LED <= rot_right(LED);
            MODE_BOUNCE: begin
              if (dir_q == DIR_UP) begin
                LED <= LED << 1;
                if (LED[WIDTH-2]) dir_q <= DIR_DOWN;
              end else begin
                LED <= LED >> 1;
                if (LED[1]) dir_q <= DIR_UP;
              end
            end
            default:    LED <= LED + WIDTH'(1);
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq (WIDTH=8): walk, bounce, count, enable
// gating, tick synchronisation and reset priority.
module tb_led_pattern_seq;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       TICK_IN;
  logic       ENABLE;
  logic [1:0] MODE;
  logic [7:0] LED;
  logic       STEP_PULSE;

  int checks = 0;
  int errors = 0;

  led_pattern_seq #(.WIDTH(8)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .TICK_IN(TICK_IN),
    .ENABLE(ENABLE),
    .MODE(MODE),
    .LED(LED),
    .STEP_PULSE(STEP_PULSE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise TICK_IN so it is sampled at edge k; the step lands at edge k+2.
  task automatic tick_step(input string tag, input logic [7:0] exp_led,
                           input logic exp_step, input bit do_chk);
    @(negedge CLOCK); TICK_IN = 1'b1;
    @(posedge CLOCK);
    @(posedge CLOCK); #1;
    if (do_chk) chk({tag, "_early"}, 32'(STEP_PULSE), 32'd0);
    @(posedge CLOCK); #1;
    if (do_chk) begin
      chk({tag, "_step"}, 32'(STEP_PULSE), 32'(exp_step));
      chk({tag, "_led"}, 32'(LED), 32'(exp_led));
    end
    @(posedge CLOCK); #1;
    if (do_chk) chk({tag, "_one"}, 32'(STEP_PULSE), 32'd0);
    @(negedge CLOCK); TICK_IN = 1'b0;
    repeat (3) @(posedge CLOCK);
  endtask

  logic [7:0] walk_l [9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] walk_r [7]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] bnc [16]    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    RESET = 1'b1; TICK_IN = 1'b0; ENABLE = 1'b1; MODE = 2'b00;
    repeat (3) @(posedge CLOCK); #1;
    chk("reset_led", 32'(LED), 32'h01);
    chk("reset_step", 32'(STEP_PULSE), 32'd0);
    @(negedge CLOCK); RESET = 1'b0;
    repeat (4) @(posedge CLOCK); #1;
    chk("release_no_step", 32'(STEP_PULSE), 32'd0);

    // Walk-left, including the MSB wrap.
    for (int i = 0; i < 9; i++) tick_step($sformatf("walkl%0d", i), walk_l[i], 1'b1, 1'b1);

    // Ticks with ENABLE low are discarded, not deferred.
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) tick_step($sformatf("dis%0d", i), 8'h02, 1'b0, 1'b1);
    @(negedge CLOCK); ENABLE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK); #1;
      chk("en_hold_step", 32'(STEP_PULSE), 32'd0);
    end
    chk("en_hold_led", 32'(LED), 32'h02);
    tick_step("en_resume", 8'h04, 1'b1, 1'b1);

    // Walk-right: reload to MSB, then rotate down and wrap.
    MODE = 2'b01;
    tick_step("walkr_load", 8'h80, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) tick_step($sformatf("walkr%0d", i), walk_r[i], 1'b1, 1'b1);
    tick_step("walkr_wrap", 8'h80, 1'b1, 1'b1);

    // MODE change between ticks does not touch LED.
    @(negedge CLOCK); MODE = 2'b10;
    repeat (6) @(posedge CLOCK); #1;
    chk("mode_idle_led", 32'(LED), 32'h80);
    chk("mode_idle_step", 32'(STEP_PULSE), 32'd0);

    // Bounce from reset.
    @(negedge CLOCK); RESET = 1'b1;
    @(posedge CLOCK); #1;
    chk("rst_mid_led", 32'(LED), 32'h01);
    @(negedge CLOCK); RESET = 1'b0;
    repeat (3) @(posedge CLOCK);
    for (int i = 0; i < 16; i++) tick_step($sformatf("bnc%0d", i), bnc[i], 1'b1, 1'b1);

    // Count: reload to 0, run to 0xFF, wrap to 0.
    MODE = 2'b11;
    tick_step("cnt_load", 8'h00, 1'b1, 1'b1);
    for (int i = 1; i <= 255; i++) tick_step("cnt_pre", 8'(i), 1'b1, 1'b0);
    #1 chk("cnt_ff", 32'(LED), 32'hFF);
    tick_step("cnt_wrap", 8'h00, 1'b1, 1'b1);
    for (int i = 1; i <= 55; i++) tick_step("cnt_pre37", 8'(i), 1'b1, 1'b0);
    #1 chk("cnt_37", 32'(LED), 32'h37);

    // Reset coincident with a tick wins.
    @(negedge CLOCK); TICK_IN = 1'b1;
    @(posedge CLOCK);
    @(posedge CLOCK);
    @(negedge CLOCK); RESET = 1'b1;
    @(posedge CLOCK); #1;
    chk("rst_tick_led", 32'(LED), 32'h01);
    chk("rst_tick_step", 32'(STEP_PULSE), 32'd0);

    // TICK_IN held high through release must not step.
    @(negedge CLOCK); RESET = 1'b0; MODE = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLOCK); #1;
      chk("held_high_step", 32'(STEP_PULSE), 32'd0);
    end
    chk("held_high_led", 32'(LED), 32'h01);
    @(negedge CLOCK); TICK_IN = 1'b0;
    repeat (4) @(posedge CLOCK);
    // Advancing (not reloading) confirms mode_q returned to walk-left.
    tick_step("first_edge", 8'h02, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
